if_prefetch: RTL and testbench
==============================

// Module: if_prefetch
// PURPOSE
//   Parametrised instruction-fetch front end; next generation of the pc_reg/iF/if_id path.
//   Issues in-order requests to an instruction memory with variable response latency.
//   Keeps up to DEPTH fetched instructions in a prefetch FIFO and feeds ID through a valid/ready handshake.
//   Flushes on EX-resolved jumps, discarding stale in-flight responses.
// PARAMETERS
//   XLEN      32       address/instruction width
//   DEPTH     4        prefetch FIFO entries; power of 2, >=2
//   RESET_PC  32'h0    first fetch address after reset
// PORTS
//   clk           in   1     clock, all logic on rising edge
//   rst           in   1     asynchronous, active-low reset
//   jump_en_i     in   1     redirect request from control
//   jump_addr_i   in   XLEN  redirect target
//   rom_req_o     out  1     fetch request valid
//   rom_addr_o    out  XLEN  fetch address (PC)
//   rom_ready_i   in   1     memory accepts request this cycle
//   rom_valid_i   in   1     response valid; responses return in request order
//   rom_inst_i    in   XLEN  response instruction
//   inst_valid_o  out  1     instruction available to ID
//   inst_ready_i  in   1     ID accepts; control drives it as ~hold_flag
//   inst_o        out  XLEN  instruction (NOP 32'h00000013 when not valid)
//   inst_addr_o   out  XLEN  address of inst_o
// BEHAVIOUR
//   Reset values: pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=BOOT.
//     rom_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0.
//   FSM: BOOT -> RUN unconditionally after one cycle; no request is issued in BOOT.
//     RUN -> FLUSH on jump_en_i when stale responses remain in flight.
//     FLUSH -> RUN when discard reaches 0 and there is no new jump.
//   Issue: rom_req_o = (state!=BOOT) && (fifo_count + outstanding < DEPTH) && !jump_en_i.
//     Accept = rom_req_o & rom_ready_i. On accept, pc += 4 and outstanding++.
//     The FIFO therefore never overflows.
//   Response: outstanding-- on each rom_valid_i.
//     If discard != 0: discard--, data dropped.
//     Otherwise push {pc_of_req, rom_inst_i}; a small address queue or a recomputed PC tracks pc_of_req.
//   Pop: inst_valid_o & inst_ready_i. inst_* shows the FIFO head, registered (no comb path from rom_*).
//   Jump: next cycle pc=jump_addr_i, FIFO cleared, discard = outstanding_next.
//     outstanding_next counts all in-flight requests, including one accepted in the jump cycle.
//     A response arriving in the jump cycle is dropped.
//     A jump overrides a simultaneous pop or push.
//     Back-to-back jumps: the last target wins and discard accumulates correctly.
//   jump_addr_i[1:0] are ignored (forced 0).
//   Counter widths are $clog2(DEPTH)+1. Wrap-around of FIFO pointers uses natural power-of-2 overflow.
//   Reset mid-operation clears everything asynchronously. Late responses from before reset are not tracked.
//     The memory is reset with the core.
// CONFIGURATION
//   IF_PREFETCH_BYPASS_EN defined:
//     When the FIFO is empty, discard==0, rom_valid_i=1 and inst_ready_i=1, the response goes straight to ID.
//     That response is presented the same cycle via a mux on inst_* and is not pushed.
//     Saves one cycle of fetch latency at the cost of a rom_valid_i->inst_valid_o comb path.
//   IF_PREFETCH_BYPASS_EN undefined: every response passes through the FIFO; minimum latency is 1 cycle.
// STRUCTURE
//   Shared header rv32i_defs.vh holds: INST_NOP 32'h00000013, the FSM state encodings
//     (BOOT/RUN/FLUSH), and the PC step constant.
//   Sub-module fifo_sync (DEPTH x 2*XLEN, push/pop/clear, count/empty/full) holds the prefetch entries.
//   Issue, discard, FSM and PC logic stay in if_prefetch.
// TESTING
//   1. Reset release, rom_ready_i=1, 1-cycle latency:
//      requests at 0x0,0x4,0x8...; inst_valid_o rises; inst_addr_o sequence 0,4,8.
//   2. inst_ready_i=0 for 10 cycles:
//      exactly DEPTH=4 requests outstanding+buffered; rom_req_o drops to 0; no entries lost after release.
//   3. 3-cycle latency, jump_en_i to 0x100 with 2 requests in flight:
//      2 responses dropped; next inst_addr_o=0x100.
//      No stale instruction ever has inst_valid_o=1.
//   4. Jump coinciding with a rom_valid_i and an inst_ready_i pop:
//      FIFO empty next cycle; both stale items discarded; fetch restarts at the target.
//   5. Random rom_ready_i/rom_valid_i latency 1-5 and random inst_ready_i for 10k cycles:
//      the inst_addr_o stream equals the golden PC sequence with jumps; no overflow.
//   6. With IF_PREFETCH_BYPASS_EN, empty FIFO, response at cycle t:
//      inst_valid_o=1 in cycle t. Without the macro: cycle t+1.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared constants and FSM encoding for the instruction-fetch front end
//   INST_NOP : instruction presented to ID when nothing is valid (addi x0,x0,0)
//   PC_STEP  : byte increment between sequential fetch addresses
//   state_e  : BOOT (no fetch yet), RUN (normal), FLUSH (stale responses still in flight)
package if_prefetch_pkg;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP  = 4;
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/if_prefetch_fifo_sync.sv
// if_prefetch_fifo_sync: DEPTH x W synchronous FIFO holding prefetched {addr, inst} entries
//   clk, rst      : clock, asynchronous active-low reset
//   push_i/pop_i  : write data_i / advance the head (caller guarantees not full / not empty)
//   clear_i       : drop all entries; wins over push and pop
//   data_o        : current head entry (register read, no input-to-output path)
//   count_o       : number of entries, $clog2(DEPTH)+1 bits
//   empty_o/full_o: occupancy flags
module if_prefetch_fifo_sync
    import if_prefetch_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    // Pointers wrap by natural power-of-two overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_i);
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch front end with in-order memory requests and a prefetch FIFO
//   clk, rst                 : clock, asynchronous active-low reset
//   jump_en_i, jump_addr_i   : redirect from control; target bits [1:0] are ignored
//   rom_req_o, rom_addr_o    : fetch request and its address (the PC)
//   rom_ready_i              : memory accepts the request this cycle
//   rom_valid_i, rom_inst_i  : in-order response from memory
//   inst_valid_o/inst_ready_i: valid/ready handshake toward ID
//   inst_o, inst_addr_o      : instruction and its address (NOP / 0 when not valid)
// Build option IF_PREFETCH_BYPASS_EN: a response arriving while the FIFO is empty and ID is
// ready is forwarded to ID in the same cycle instead of being pushed.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            rom_req_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic            rom_ready_i,
    input  logic            rom_valid_i,
    input  logic [XLEN-1:0] rom_inst_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o
);
    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam int              CW1  = CW + 1;
    localparam logic [XLEN-1:0] NOP  = XLEN'(INST_NOP);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, rpc_q, rpc_d, tgt;
    logic [CW-1:0]     out_q, out_d, disc_q, disc_d, cnt;
    logic [CW1-1:0]    used;
    logic              acc, rsp, keep, byp, push, pop, empty, full;
    logic [2*XLEN-1:0] head;
    assign tgt  = jump_addr_i & ~XLEN'(3);
    // Buffered plus in-flight entries bound issue, so every response has a FIFO slot.
    assign used = CW1'(cnt) + CW1'(out_q);
    assign rom_req_o  = state_q != ST_BOOT && used < CW1'(DEPTH) && !jump_en_i;
    assign rom_addr_o = pc_q;
    assign acc  = rom_req_o && rom_ready_i;
    // Responses with nothing outstanding (e.g. from before a reset) are ignored.
    assign rsp  = rom_valid_i && out_q != '0;
    assign keep = rsp && disc_q == '0 && !jump_en_i;
`ifdef IF_PREFETCH_BYPASS_EN
    assign byp = keep && empty && inst_ready_i;
`else
    assign byp = 1'b0;
`endif
    assign push = keep && !byp && !full;
    assign pop  = !empty && inst_ready_i && !jump_en_i;
    assign inst_valid_o = !empty || byp;
    assign inst_o       = !empty ? head[XLEN-1:0] : byp ? rom_inst_i : NOP;
    assign inst_addr_o  = !empty ? head[2*XLEN-1:XLEN] : byp ? rpc_q : '0;
    // rpc_q is the address of the next response that will be kept: responses return in
    // order and requests are sequential from the last jump target.
    always_comb begin
        out_d  = out_q + CW'(acc) - CW'(rsp);
        disc_d = jump_en_i ? out_d : disc_q - CW'(rsp && disc_q != '0);
        pc_d   = jump_en_i ? tgt : acc ? pc_q + STEP : pc_q;
        rpc_d  = jump_en_i ? tgt : keep ? rpc_q + STEP : rpc_q;
        state_d = state_q;
        if (state_q == ST_BOOT) state_d = ST_RUN;
        else if (jump_en_i) state_d = (out_d != '0) ? ST_FLUSH : ST_RUN;
        else if (state_q == ST_FLUSH && disc_q == '0) state_d = ST_RUN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            rpc_q   <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end
    if_prefetch_fifo_sync #(.W(2 * XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (jump_en_i),
        .data_i  ({rpc_q, rom_inst_i}),
        .data_o  (head),
        .count_o (cnt),
        .empty_o (empty),
        .full_o  (full)
    );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed table, corner sequences and randomized run against a golden PC stream
module tb_if_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    logic        clk = 1'b0, rst = 1'b0;
    logic        jump_en_i = 1'b0, rom_ready_i = 1'b0, rom_valid_i = 1'b0, inst_ready_i = 1'b0;
    logic [31:0] jump_addr_i = '0, rom_inst_i = '0;
    logic        rom_req_o, inst_valid_o;
    logic [31:0] rom_addr_o, inst_o, inst_addr_o;

    if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ready_i(rom_ready_i),
        .rom_valid_i(rom_valid_i), .rom_inst_i(rom_inst_i), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, vld;
        logic [31:0] raddr;
        logic        ird, ereq;
        logic [31:0] eaddr;
        logic        eivld;
        logic [31:0] eiaddr;
    } vec_t;

    int          total = 0, bad = 0, cyc = 0;
    int          npop, nacc, tv, tiv, pend_t[$];
    logic [31:0] pend_a[$], exp_pc, exp_req, first_ia, s_addr;
    logic        seen, s_req, s_ivld;
    vec_t        tbl[8];

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic vec_t mkv(input logic rdy, input logic vld, input logic [31:0] ra,
                                 input logic ird, input logic ereq, input logic [31:0] ea,
                                 input logic eiv, input logic [31:0] eia);
        vec_t v;
        v.rdy = rdy; v.vld = vld; v.raddr = ra; v.ird = ird;
        v.ereq = ereq; v.eaddr = ea; v.eivld = eiv; v.eiaddr = eia;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; rom_ready_i = 1'b0;
        rom_valid_i = 1'b0; rom_inst_i = '0; inst_ready_i = 1'b0;
        pend_a.delete(); pend_t.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        cyc = 0; exp_pc = '0; exp_req = '0; npop = 0; nacc = 0; tv = -1; tiv = -1; seen = 1'b0;
    endtask

    // One cycle: memory model answers in order after its latency, golden stream is checked.
    task automatic step(input logic jmp, input logic [31:0] ja, input logic ird,
                        input logic rdy, input int lat);
        logic vld;
        logic [31:0] ra;
        @(negedge clk);
        vld = pend_a.size() != 0 && pend_t[0] <= cyc;
        ra  = vld ? pend_a[0] : 32'h0;
        jump_en_i = jmp; jump_addr_i = ja; inst_ready_i = ird; rom_ready_i = rdy;
        rom_valid_i = vld; rom_inst_i = vld ? mk_inst(ra) : 32'h0;
        #1;
        s_req = rom_req_o; s_addr = rom_addr_o; s_ivld = inst_valid_o;
        if (vld && tv < 0) tv = cyc;
        if (inst_valid_o && tiv < 0) tiv = cyc;
        if (rom_req_o) begin
            chk("req_during_jump", {31'b0, jmp}, 32'h0);
            chk("req_addr", rom_addr_o, exp_req);
        end
        if (inst_valid_o && !jmp) begin
            chk("inst_addr", inst_addr_o, exp_pc);
            chk("inst_data", inst_o, mk_inst(exp_pc));
            if (!seen) begin seen = 1'b1; first_ia = inst_addr_o; end
            if (ird) begin exp_pc += 4; npop++; end
        end
        if (vld) begin void'(pend_a.pop_front()); void'(pend_t.pop_front()); end
        if (rom_req_o && rdy) begin
            pend_a.push_back(rom_addr_o); pend_t.push_back(cyc + lat);
            exp_req += 4; nacc++;
        end
        if (jmp) begin exp_pc = ja & ~32'h3; exp_req = ja & ~32'h3; end
        chk("in_flight_bound", {31'b0, pend_a.size() > DEPTH}, 32'h0);
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        tbl[0] = mkv(1'b1, 1'b0, 0,  1'b1, 1'b0, 0,  1'b0, 0);
        tbl[1] = mkv(1'b1, 1'b0, 0,  1'b1, 1'b1, 0,  1'b0, 0);
        tbl[2] = mkv(1'b1, 1'b1, 0,  1'b1, 1'b1, 4,  1'b0, 0);
        tbl[3] = mkv(1'b1, 1'b1, 4,  1'b1, 1'b1, 8,  1'b1, 0);
        tbl[4] = mkv(1'b1, 1'b1, 8,  1'b1, 1'b1, 12, 1'b1, 4);
        tbl[5] = mkv(1'b1, 1'b1, 12, 1'b1, 1'b1, 16, 1'b1, 8);
        tbl[6] = mkv(1'b1, 1'b1, 16, 1'b1, 1'b1, 20, 1'b1, 12);
        tbl[7] = mkv(1'b1, 1'b1, 20, 1'b1, 1'b1, 24, 1'b1, 16);

        // reset values, observed while reset is held
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'b0, rom_req_o}, 32'h0);
        chk("rst_pc", rom_addr_o, 32'h0);
        chk("rst_ivld", {31'b0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, 32'h0);

        // 1: sequential fetch, 1-cycle latency, vector table
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int j;
            @(negedge clk);
            rom_ready_i = tbl[i].rdy; rom_valid_i = tbl[i].vld;
            rom_inst_i = tbl[i].vld ? mk_inst(tbl[i].raddr) : 32'h0;
            inst_ready_i = tbl[i].ird; jump_en_i = 1'b0;
            #1;
            chk("t1_req", {31'b0, rom_req_o}, {31'b0, tbl[i].ereq});
            chk("t1_addr", rom_addr_o, tbl[i].eaddr);
            j = i + BYP;
            if (j < 8) begin
                chk("t1_ivld", {31'b0, inst_valid_o}, {31'b0, tbl[j].eivld});
                chk("t1_iaddr", inst_addr_o, tbl[j].eivld ? tbl[j].eiaddr : 32'h0);
                chk("t1_inst", inst_o, tbl[j].eivld ? mk_inst(tbl[j].eiaddr) : NOP);
            end
        end

        // 2: ID stalled, fetch must stop at DEPTH entries and lose nothing
        do_reset();
        repeat (12) step(1'b0, 0, 1'b0, 1'b1, 1);
        chk("t2_accepts", nacc, DEPTH);
        chk("t2_req_low", {31'b0, s_req}, 32'h0);
        repeat (12) step(1'b0, 0, 1'b1, 1'b1, 1);
        chk("t2_drained", {31'b0, npop >= DEPTH}, 32'h1);

        // 3: 3-cycle latency, jump with two requests in flight
        do_reset();
        repeat (3) step(1'b0, 0, 1'b1, 1'b1, 3);
        chk("t3_in_flight", pend_a.size(), 2);
        step(1'b1, 32'h100, 1'b1, 1'b1, 3);
        repeat (15) step(1'b0, 0, 1'b1, 1'b1, 3);
        chk("t3_first_addr", first_ia, 32'h100);
        chk("t3_progress", {31'b0, npop > 0}, 32'h1);

        // 4: jump together with a response and a pop
        do_reset();
        repeat (4) step(1'b0, 0, 1'b1, 1'b1, 1);
        step(1'b1, 32'h203, 1'b1, 1'b1, 1);
        step(1'b0, 0, 1'b1, 1'b1, 1);
        chk("t4_empty", {31'b0, s_ivld}, 32'h0);
        chk("t4_req", {31'b0, s_req}, 32'h1);
        chk("t4_restart", s_addr, 32'h200);
        n0 = npop;
        repeat (6) step(1'b0, 0, 1'b1, 1'b1, 1);
        chk("t4_progress", {31'b0, npop > n0}, 32'h1);

        // 6: response-to-ID latency from an empty FIFO
        do_reset();
        step(1'b0, 0, 1'b1, 1'b0, 1);
        step(1'b0, 0, 1'b1, 1'b1, 2);
        repeat (8) step(1'b0, 0, 1'b1, 1'b0, 1);
        chk("t6_latency", tiv - tv, 1 - BYP);

        // 5: random handshakes, latencies and jumps
        do_reset();
        for (int k = 0; k < 10000; k++)
            step($urandom_range(0, 39) == 0, $urandom & 32'h0000_0fff,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(1, 5));
        chk("t5_progress", {31'b0, npop >= 1000}, 32'h1);

        // asynchronous reset mid-operation
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, rom_req_o}, 32'h0);
        chk("async_rst_ivld", {31'b0, inst_valid_o}, 32'h0);
        chk("async_rst_pc", rom_addr_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
